// File: rtl/noc_pkg.sv
// Shared mesh-router definitions: flit types, port indices, idle select code
// and small helpers used by the schedulers and pickers.
package noc_pkg;

  localparam int NUM_PORTS = 5;

  localparam logic [2:0] PORT_N = 3'd0;
  localparam logic [2:0] PORT_S = 3'd1;
  localparam logic [2:0] PORT_W = 3'd2;
  localparam logic [2:0] PORT_E = 3'd3;
  localparam logic [2:0] PORT_L = 3'd4;

  // Crossbar select value that makes the mux output zero
  localparam logic [2:0] SEL_IDLE = 3'b111;

  typedef enum logic [1:0] {
    FT_BODY   = 2'b00,
    FT_TAIL   = 2'b01,
    FT_HEAD   = 2'b10,
    FT_SINGLE = 2'b11
  } flit_type_t;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } sched_state_t;

  // Reduce a value in 0..9 to 0..4 (port index arithmetic modulo 5)
  function automatic logic [2:0] wrap5(input logic [3:0] v);
    return (v >= 4'd5) ? 3'(v - 4'd5) : v[2:0];
  endfunction

  // HEAD and SINGLE both open a packet; they share the set MSB
  function automatic logic starts_pkt(input logic [1:0] t);
    return t[1];
  endfunction

endpackage

// File: rtl/output_port_scheduler_if.sv
// Request/grant bundle between input buffers, scheduler, crossbar and
// credit counter for one router output.
interface output_port_scheduler_if;
  logic [4:0] req_i;
  logic [9:0] flit_type_i;
  logic       credit_i;
  logic [2:0] sel_o;
  logic [4:0] read_o;
  logic       cc_dec_o;
  logic       valid_o;

  modport master (
    output req_i, flit_type_i, credit_i,
    input  sel_o, read_o, cc_dec_o, valid_o
  );

  modport slave (
    input  req_i, flit_type_i, credit_i,
    output sel_o, read_o, cc_dec_o, valid_o
  );
endinterface

// File: rtl/rr_pick5.sv
// Combinational 5-way round-robin picker: first requester at or after ptr.
module rr_pick5
  import noc_pkg::*;
(
  input  logic [4:0] req,
  input  logic [2:0] ptr,
  output logic [2:0] gnt_idx,
  output logic       any
);

  logic [2:0]           cand_idx [NUM_PORTS];
  logic [NUM_PORTS-1:0] cand_req;

  // Rotate the request vector so offset 0 is the current priority holder
  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_rot
    assign cand_idx[gi] = wrap5({1'b0, ptr} + 4'(gi));
    assign cand_req[gi] = req[cand_idx[gi]];
  end

  // Scan from the far end so the lowest rotated offset wins
  always_comb begin
    gnt_idx = 3'd0;
    any     = 1'b0;
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
      if (cand_req[k]) begin
        gnt_idx = cand_idx[k];
        any     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/output_port_scheduler.sv
// Wormhole scheduler for one router output: round-robin grant on HEAD/SINGLE,
// then hold the crossbar on the winner until its TAIL (or SINGLE) leaves.
module output_port_scheduler
  import noc_pkg::*;
#(
  parameter int FLIT_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  output_port_scheduler_if.slave port_if,
  output logic                 busy_o,
  output logic                 err_o,
  output logic [CNT_W-1:0]     pkt_cnt_o
);

  // Flit type lives in the top two flit bits, so narrower flits are meaningless
  if (FLIT_W < 2) begin : g_bad_flit_w
    $error("output_port_scheduler: FLIT_W must be at least 2");
  end

  sched_state_t     state_q, state_d;
  logic [2:0]       owner_q, owner_d;
  logic [2:0]       rr_ptr_q, rr_ptr_d;
  logic             first_q, first_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] pkt_cnt_q, pkt_cnt_d;

  logic [1:0]           type_arr [NUM_PORTS];
  logic [NUM_PORTS-1:0] eligible;
  logic [NUM_PORTS-1:0] bad_idle;
  logic [2:0]           pick_idx;
  logic                 pick_any;
  flit_type_t           owner_type;
  logic                 xfer;
  logic                 proto_err;

  // Split the packed type bus and classify each head-of-line flit
  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_in
    assign type_arr[gi] = port_if.flit_type_i[2*gi +: 2];
    assign eligible[gi] = port_if.req_i[gi] & starts_pkt(type_arr[gi]);
    assign bad_idle[gi] = port_if.req_i[gi] & ~starts_pkt(type_arr[gi]);
  end

  rr_pick5 u_pick (
    .req     (eligible),
    .ptr     (rr_ptr_q),
    .gnt_idx (pick_idx),
    .any     (pick_any)
  );

  assign owner_type = flit_type_t'(type_arr[owner_q]);
  assign xfer       = (state_q == ST_LOCKED) & port_if.req_i[owner_q] & port_if.credit_i;
  // A packet must open on HEAD/SINGLE and never reopen mid-packet
  assign proto_err  = first_q ? ~starts_pkt(owner_type) : starts_pkt(owner_type);

  // Next-state, grant/lock control and the per-cycle crossbar/pop/credit pulses
  always_comb begin
    state_d          = state_q;
    owner_d          = owner_q;
    rr_ptr_d         = rr_ptr_q;
    first_d          = first_q;
    err_d            = err_q;
    pkt_cnt_d        = pkt_cnt_q;
    port_if.sel_o    = SEL_IDLE;
    port_if.read_o   = 5'b00000;
    port_if.cc_dec_o = 1'b0;
    port_if.valid_o  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // BODY/TAIL at a head-of-line while nobody owns the output is a lost packet start
        if (|bad_idle) err_d = 1'b1;
        // Grant only; the head flit moves in the following cycle
        if (pick_any && port_if.credit_i) begin
          state_d = ST_LOCKED;
          owner_d = pick_idx;
          first_d = 1'b1;
        end
      end
      ST_LOCKED: begin
        port_if.sel_o = owner_q;
        if (xfer) begin
          port_if.read_o   = 5'b00001 << owner_q;
          port_if.cc_dec_o = 1'b1;
          port_if.valid_o  = 1'b1;
          if (proto_err) begin
            // Forward anyway and keep the lock; the flag is sticky
            err_d   = 1'b1;
            first_d = 1'b0;
          end else if (owner_type == FT_TAIL || owner_type == FT_SINGLE) begin
            state_d   = ST_IDLE;
            rr_ptr_d  = wrap5({1'b0, owner_q} + 4'd1);
            pkt_cnt_d = pkt_cnt_q + CNT_W'(1);
          end else begin
            first_d = 1'b0;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and bookkeeping registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      owner_q   <= 3'd0;
      rr_ptr_q  <= 3'd0;
      first_q   <= 1'b0;
      err_q     <= 1'b0;
      pkt_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      rr_ptr_q  <= rr_ptr_d;
      first_q   <= first_d;
      err_q     <= err_d;
      pkt_cnt_q <= pkt_cnt_d;
    end
  end

  assign busy_o    = (state_q == ST_LOCKED);
  assign err_o     = err_q;
  assign pkt_cnt_o = pkt_cnt_q;

endmodule

// File: doc/output_port_scheduler.md
# output_port_scheduler

Per-output-port wormhole scheduler for the 5-port (N, S, W, E, L) mesh router. It arbitrates round-robin among input buffers whose head-of-line flit targets this output and locks the output to the winner from head flit to tail flit. While locked, it drives the crossbar mux select, the input-buffer pop pulse and the credit-counter decrement, stalling on empty buffer or zero downstream credit. One instance sits per router output, between the YX route compute/input buffers and the crossbar mux/credit counter.

## Interface

Parameters:
- FLIT_W, 16, flit width; flit type is carried in bits [FLIT_W-1:FLIT_W-2]
- CNT_W, 16, width of the completed-packet counter

Ports (input index 0=N, 1=S, 2=W, 3=E, 4=L):
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- req_i  in  5  bit i: input i buffer non-empty and its head-of-line flit routes to this output
- flit_type_i  in  10  [2i+1:2i] = type of input i head-of-line flit; 2'b10 HEAD, 2'b00 BODY, 2'b01 TAIL, 2'b11 SINGLE
- credit_i  in  1  downstream credit counter non-zero
- sel_o  out  3  crossbar mux select: owner index 0..4; 3'b111 = idle (mux outputs zero)
- read_o  out  5  one-hot pop pulse to input buffer of owner
- cc_dec_o  out  1  decrement pulse to this output's credit counter
- valid_o  out  1  flit driven on output link this cycle
- busy_o  out  1  output locked to an input
- err_o  out  1  sticky protocol-error flag
- pkt_cnt_o  out  CNT_W  completed packets, wraps

## Operation

- States: IDLE, LOCKED. Registers: state, owner[2:0], rr_ptr[2:0], first (next flit of packet is the first), err, pkt_cnt.
- Eligible in IDLE: req_i[i] & type_i ∈ {HEAD, SINGLE}. req_i[i] with type BODY/TAIL in IDLE: input ignored, err set.
- IDLE → LOCKED when any eligible & credit_i: owner <= first eligible index searching rr_ptr, rr_ptr+1, … (mod 5); first <= 1. No flit moves in the grant cycle.
- LOCKED: xfer = req_i[owner] & credit_i. read_o = xfer ? (1 << owner) : 0; cc_dec_o = valid_o = xfer; sel_o = owner.
- LOCKED, xfer, type TAIL, or first & type SINGLE: → IDLE; rr_ptr <= (owner+1) mod 5; pkt_cnt += 1.
- LOCKED, xfer, other type: stay; first <= 0.
- Errors (set err, stay LOCKED, flit still forwarded): first & type ∉ {HEAD, SINGLE}; !first & type ∈ {HEAD, SINGLE}.
- Requests from non-owner inputs while LOCKED are ignored, including HEAD flits.
- Stall (req_i[owner]=0 or credit_i=0): lock held, all pulses 0, sel_o held.
- In IDLE: sel_o = 3'b111, read_o = 0, cc_dec_o = valid_o = 0.

## Timing

- Reset (sync, any state including mid-packet): state IDLE, owner 0, rr_ptr 0 (N highest priority), first 0, err 0, pkt_cnt 0. Outputs: sel_o 3'b111, read_o 0, cc_dec_o 0, valid_o 0, busy_o 0, err_o 0, pkt_cnt_o 0.
- Grant latency: eligible request at edge k → busy_o/sel_o valid after edge k+1 → head flit xfer in cycle k+1 if credit_i.
- read_o, cc_dec_o, valid_o: combinational from registered state/owner and current req_i/credit_i; no registered datapath stage.
- Throughput: 1 flit/cycle while locked. An N-flit packet occupies N+1 cycles with no stalls; the next grant needs 1 IDLE cycle.
- Simultaneous tail xfer and another input's head: the new head is arbitrated only in the following IDLE cycle.
- pkt_cnt wraps 2^CNT_W-1 → 0. err_o clears only on reset.

## Structure

- Shared package noc_pkg: flit_type_t enum (HEAD/BODY/TAIL/SINGLE encodings), port index constants PORT_N..PORT_L, SEL_IDLE = 3'b111, NUM_PORTS = 5.
- Sub-module rr_pick5: combinational 5-way round-robin picker (req[4:0], ptr[2:0] → gnt_idx[2:0], any). It is reusable by the local-port injector.
- Remaining logic (FSM, counters, pulses) is in output_port_scheduler, about 150–250 lines.

## Test plan

- Reset → sel_o=7, busy_o=0, pkt_cnt_o=0. Then req_i=5'b00010 (S HEAD) for 1 cycle with credit_i=1 → busy_o=1, sel_o=1; next cycle read_o=5'b00010.
- S sends HEAD, BODY, BODY, TAIL with credit_i=1 → 4 consecutive xfers, sel_o=1 throughout, pkt_cnt_o=1, rr_ptr=2.
- N and L both present HEAD after reset, each with 2-flit packets → N served first, then L. Repeat → L wins only if rr_ptr passes it; grant order checked over 3 rounds.
- Mid-packet credit_i=0 for 3 cycles, then S buffer empties for 2 cycles → no read_o/cc_dec_o pulses, lock held, the packet completes intact.
- E presents SINGLE → one xfer, immediate return to IDLE, pkt_cnt_o +1. W presents BODY while IDLE → err_o=1, no grant.
- Reset asserted mid-packet (after the S HEAD) → next cycle IDLE, sel_o=7, err_o=0. Separately, with pkt_cnt preloaded to 16'hFFFF, one more packet → pkt_cnt_o=0.
